// File: rtl/alignment_collector_if.sv
// Handshake bundle between the traceback source, the collector and the downstream consumer.
// master: the side that feeds traceback pairs and accepts replayed pairs; slave: the collector.
interface alignment_collector_if;
  logic       in_valid;
  logic       in_done;
  logic [2:0] seq1_in;
  logic [2:0] seq2_in;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] seq1_o;
  logic [2:0] seq2_o;
  logic       out_last;

  modport master (
    output in_valid, in_done, seq1_in, seq2_in, out_ready,
    input  out_valid, seq1_o, seq2_o, out_last
  );

  modport slave (
    input  in_valid, in_done, seq1_in, seq2_in, out_ready,
    output out_valid, seq1_o, seq2_o, out_last
  );
endinterface

// File: rtl/alignment_collector.sv
// Buffers an end-first Smith-Waterman traceback in a LIFO and replays it start-first with stats.
// Optional recomputed alignment score is built only when ALN_SCORE_EN is defined.
//
// state  | meaning
// S_IDLE | waiting for the first traceback pair
// S_FILL | pushing pairs until in_done
// S_EMIT | popping pairs to the downstream stream
module alignment_collector #(
  parameter int         N              = 8,
  parameter int         MAX_LEN        = 2 * N,
  parameter logic [2:0] GAP_CODE       = 3'b010,
  parameter int         MATCH_SCORE    = 2,
  parameter int         MISMATCH_SCORE = 1,
  parameter int         GAP_PENALTY    = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  alignment_collector_if.slave  bus,
  output logic [7:0]            aln_len,
  output logic [7:0]            n_match,
  output logic [7:0]            n_mismatch,
  output logic [7:0]            n_gap,
  output logic                  overflow,
  output logic                  busy_drop,
  output logic [15:0]           aln_score
);

  localparam int AW = $clog2(MAX_LEN);

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_EMIT} state_t;

  state_t        state;
  state_t        state_nxt;
  logic [7:0]    ptr;
  logic [5:0]    mem [MAX_LEN];
  logic [AW-1:0] wr_idx;
  logic [AW-1:0] rd_idx;
  logic          full;
  logic          is_gap;
  logic          is_match;
  logic          is_mismatch;
  logic          first;
  logic          push;
  logic          drop_full;
  logic          drop_busy;
  logic          fire;

  assign wr_idx      = AW'(ptr);
  assign rd_idx      = AW'(ptr - 8'd1);
  assign full        = (ptr == 8'(MAX_LEN));
  assign is_gap      = (bus.seq1_in == GAP_CODE) || (bus.seq2_in == GAP_CODE);
  assign is_match    = !is_gap && (bus.seq1_in == bus.seq2_in);
  assign is_mismatch = !is_gap && (bus.seq1_in != bus.seq2_in);

  // clear wins over any incoming pair in the same cycle
  assign first     = !clear && bus.in_valid && (state == S_IDLE);
  assign push      = first || (!clear && bus.in_valid && (state == S_FILL) && !full);
  assign drop_full = !clear && bus.in_valid && (state == S_FILL) && full;
  assign drop_busy = !clear && bus.in_valid && (state == S_EMIT);
  assign fire      = bus.out_valid && bus.out_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (bus.in_valid) state_nxt = bus.in_done ? S_EMIT : S_FILL;
      S_FILL: if (bus.in_done) state_nxt = (bus.in_valid || ptr != 8'd0) ? S_EMIT : S_IDLE;
      S_EMIT: if (fire && ptr == 8'd1) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    if (clear) state_nxt = S_IDLE;
  end

  always_comb begin
    bus.out_valid = (state == S_EMIT);
    bus.out_last  = bus.out_valid && (ptr == 8'd1);
    bus.seq1_o    = bus.out_valid ? mem[rd_idx][5:3] : 3'd0;
    bus.seq2_o    = bus.out_valid ? mem[rd_idx][2:0] : 3'd0;
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_idx] <= {bus.seq1_in, bus.seq2_in};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr        <= 8'd0;
      aln_len    <= 8'd0;
      n_match    <= 8'd0;
      n_mismatch <= 8'd0;
      n_gap      <= 8'd0;
      overflow   <= 1'b0;
      busy_drop  <= 1'b0;
    end else if (clear) begin
      ptr        <= 8'd0;
      aln_len    <= 8'd0;
      n_match    <= 8'd0;
      n_mismatch <= 8'd0;
      n_gap      <= 8'd0;
      overflow   <= 1'b0;
      busy_drop  <= 1'b0;
    end else begin
      if (push)      ptr <= ptr + 8'd1;
      else if (fire) ptr <= ptr - 8'd1;
      if (drop_full) overflow  <= 1'b1;
      if (drop_busy) busy_drop <= 1'b1;
      // stats restart on the first pair of a new alignment and then hold until the next one
      if (push) begin
        aln_len    <= (first ? 8'd0 : aln_len)    + 8'd1;
        n_match    <= (first ? 8'd0 : n_match)    + {7'd0, is_match};
        n_mismatch <= (first ? 8'd0 : n_mismatch) + {7'd0, is_mismatch};
        n_gap      <= (first ? 8'd0 : n_gap)      + {7'd0, is_gap};
      end
    end
  end

`ifdef ALN_SCORE_EN
  logic [15:0] score_delta;

  always_comb begin
    score_delta = 16'(MATCH_SCORE);
    if (is_gap)           score_delta = -16'(GAP_PENALTY);
    else if (is_mismatch) score_delta = -16'(MISMATCH_SCORE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)     aln_score <= 16'd0;
    else if (clear) aln_score <= 16'd0;
    else if (push)  aln_score <= (first ? 16'd0 : aln_score) + score_delta;
  end
`else
  // score weights are meaningless without the score datapath
  logic [2:0] unused_score_cfg;
  assign unused_score_cfg = {MATCH_SCORE[0], MISMATCH_SCORE[0], GAP_PENALTY[0]};
  assign aln_score        = 16'd0;
`endif

endmodule

// File: tb/tb_alignment_collector.sv
// Directed bench for alignment_collector: a queue model predicts the replayed pairs and the stats.
module tb_alignment_collector;
  localparam int MAX_LEN = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        clear = 1'b0;
  logic [7:0]  aln_len, n_match, n_mismatch, n_gap;
  logic        overflow, busy_drop;
  logic [15:0] aln_score;

  always #5 clk = ~clk;

  alignment_collector_if bus ();

  alignment_collector dut (
    .clk        (clk),
    .reset      (reset),
    .clear      (clear),
    .bus        (bus),
    .aln_len    (aln_len),
    .n_match    (n_match),
    .n_mismatch (n_mismatch),
    .n_gap      (n_gap),
    .overflow   (overflow),
    .busy_drop  (busy_drop),
    .aln_score  (aln_score)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [2:0] s1q[$];
  logic [2:0] s2q[$];
  logic [6:0] exp_q[$];
  int         m_len, m_match, m_mis, m_gap;
  bit         m_ovf, m_busy;

  bit         ready_mode = 1'b0;
  bit  [3:0]  ready_pat = 4'b1001;
  logic [1:0] rk = 2'd0;

  bit         st_prev = 1'b0;
  logic [5:0] st_data = 6'd0;

  task automatic check(input string name, input int act, input int req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // downstream ready: always 1, or the repeating 1,0,0,1 pattern
  always @(posedge clk) begin
    #1;
    if (!ready_mode) bus.out_ready = 1'b1;
    else begin
      bus.out_ready = ready_pat[rk];
      rk = rk + 2'd1;
    end
  end

  always @(negedge clk) begin
    if (!reset) st_prev = 1'b0;
    else begin
      check("invariant_sum", int'(n_match) + int'(n_mismatch) + int'(n_gap), int'(aln_len));
      if (exp_q.size() == 0) check("valid_without_pair", int'(bus.out_valid), 0);
      if (bus.out_valid) begin
        if (st_prev) check("stall_hold", int'({bus.seq1_o, bus.seq2_o}), int'(st_data));
        if (bus.out_ready && exp_q.size() != 0)
          check("out_pair_last", int'({bus.seq1_o, bus.seq2_o, bus.out_last}), int'(exp_q.pop_front()));
      end
      st_prev = bus.out_valid && !bus.out_ready;
      st_data = {bus.seq1_o, bus.seq2_o};
    end
  end

  task automatic model_zero();
    m_len = 0; m_match = 0; m_mis = 0; m_gap = 0;
    m_ovf = 1'b0; m_busy = 1'b0;
    exp_q.delete();
  endtask

  // the first MAX_LEN pairs survive; they come out in reverse of arrival order
  task automatic model_load();
    int n, acc;
    logic [6:0] e;
    n = s1q.size();
    acc = (n < MAX_LEN) ? n : MAX_LEN;
    m_len = acc; m_match = 0; m_mis = 0; m_gap = 0;
    for (int i = 0; i < acc; i++) begin
      if (s1q[i] == 3'd2 || s2q[i] == 3'd2) m_gap++;
      else if (s1q[i] == s2q[i])            m_match++;
      else                                  m_mis++;
    end
    for (int i = acc - 1; i >= 0; i--) begin
      e = {s1q[i], s2q[i], (i == 0)};
      exp_q.push_back(e);
    end
    if (n > acc) m_ovf = 1'b1;
  endtask

  task automatic feed(input bit done_sep, input bit no_done);
    for (int i = 0; i < s1q.size(); i++) begin
      @(posedge clk); #1;
      bus.in_valid = 1'b1;
      bus.seq1_in  = s1q[i];
      bus.seq2_in  = s2q[i];
      bus.in_done  = !done_sep && !no_done && (i == s1q.size() - 1);
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_done  = done_sep && !no_done;
    if (done_sep && !no_done) begin
      @(posedge clk); #1;
      bus.in_done = 1'b0;
    end
  endtask

  task automatic wait_drain(input string tag);
    int t = 0;
    while ((exp_q.size() != 0 || bus.out_valid) && t < 300) begin
      @(negedge clk);
      t++;
    end
    check({tag, "_drain_in_bound"}, int'(t < 300), 1);
  endtask

  task automatic do_clear(input bit with_valid);
    @(posedge clk); #1;
    clear = 1'b1;
    if (with_valid) begin
      bus.in_valid = 1'b1; bus.seq1_in = 3'd6; bus.seq2_in = 3'd6;
    end
    @(posedge clk); #1;
    clear = 1'b0;
    bus.in_valid = 1'b0;
    model_zero();
  endtask

  task automatic check_status(input string tag);
    check({tag, "_aln_len"},    int'(aln_len),    m_len);
    check({tag, "_n_match"},    int'(n_match),    m_match);
    check({tag, "_n_mismatch"}, int'(n_mismatch), m_mis);
    check({tag, "_n_gap"},      int'(n_gap),      m_gap);
    check({tag, "_overflow"},   int'(overflow),   int'(m_ovf));
    check({tag, "_busy_drop"},  int'(busy_drop),  int'(m_busy));
`ifdef ALN_SCORE_EN
    check({tag, "_aln_score"}, int'($signed(aln_score)), 2 * m_match - m_mis - m_gap);
`else
    check({tag, "_aln_score"}, int'(aln_score), 0);
`endif
  endtask

  task automatic load_case1();
    s1q = '{3'd3, 3'd1, 3'd5, 3'd0};
    s2q = '{3'd3, 3'd2, 3'd2, 3'd0};
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid = 1'b0; bus.in_done = 1'b0;
    bus.seq1_in = 3'd0;  bus.seq2_in = 3'd0;
    bus.out_ready = 1'b1;
    model_zero();
    #12;
    check("rst_out_valid", int'(bus.out_valid), 0);
    check("rst_out_last",  int'(bus.out_last), 0);
    check("rst_seq1_o",    int'(bus.seq1_o), 0);
    check_status("rst");
    @(negedge clk); reset = 1'b1;

    // case 1: four pairs, always ready
    load_case1(); model_load(); feed(1'b0, 1'b0); wait_drain("t1");
    check_status("t1");
    check("t1_len_lit",      int'(aln_len), 4);
    check("t1_match_lit",    int'(n_match), 2);
    check("t1_mismatch_lit", int'(n_mismatch), 0);
    check("t1_gap_lit",      int'(n_gap), 2);
`ifdef ALN_SCORE_EN
    check("t1_score_lit", int'($signed(aln_score)), 2);
`endif

    // case 2: same pairs with ready 1,0,0,1
    ready_mode = 1'b1; rk = 2'd0;
    load_case1(); model_load(); feed(1'b0, 1'b0); wait_drain("t2");
    check_status("t2");
    ready_mode = 1'b0;

    // single-pair alignment straight from IDLE
    s1q = '{3'd2}; s2q = '{3'd5};
    model_load(); feed(1'b0, 1'b0); wait_drain("t_single");
    check_status("t_single");
    check("t_single_gap_lit", int'(n_gap), 1);

    // done arriving on its own beat after the last pair
    s1q = '{3'd4, 3'd6, 3'd7}; s2q = '{3'd4, 3'd1, 3'd7};
    model_load(); feed(1'b1, 1'b0); wait_drain("t_sepdone");
    check_status("t_sepdone");
    check("t_sepdone_mis_lit", int'(n_mismatch), 1);

    // case 3: 20 pairs into a 16-deep LIFO
    s1q.delete(); s2q.delete();
    for (int i = 0; i < 20; i++) begin
      s1q.push_back(3'(i % 8));
      s2q.push_back(3'((i * 3) % 8));
    end
    model_load(); feed(1'b0, 1'b0); wait_drain("t3");
    check_status("t3");
    check("t3_len_lit", int'(aln_len), 16);
    check("t3_ovf_lit", int'(overflow), 1);
    do_clear(1'b0);
    check_status("t3_clr");

    // case 4: traffic during EMIT is dropped
    ready_mode = 1'b1; rk = 2'd0;
    load_case1(); model_load(); feed(1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      bus.in_valid = 1'b1; bus.seq1_in = 3'd7; bus.seq2_in = 3'd7;
    end
    @(posedge clk); #1; bus.in_valid = 1'b0;
    m_busy = 1'b1;
    wait_drain("t4");
    check_status("t4");
    check("t4_busy_lit", int'(busy_drop), 1);
    ready_mode = 1'b0;
    do_clear(1'b0);

    // case 5: clear mid-fill (colliding with a pair), then a fresh 2-pair alignment
    s1q = '{3'd1, 3'd4, 3'd0, 3'd5, 3'd6}; s2q = '{3'd1, 3'd3, 3'd0, 3'd5, 3'd2};
    feed(1'b0, 1'b1);
    do_clear(1'b1);
    check_status("t5_clr");
    s1q = '{3'd1, 3'd3}; s2q = '{3'd1, 3'd6};
    model_load(); feed(1'b0, 1'b0); wait_drain("t5");
    check_status("t5");
    check("t5_len_lit", int'(aln_len), 2);

    // case 6: reset asserted mid-EMIT
    ready_mode = 1'b1; rk = 2'd0;
    load_case1(); model_load(); feed(1'b0, 1'b0);
    @(negedge clk);
    check("t6_in_emit", int'(bus.out_valid), 1);
    reset = 1'b0;
    model_zero();
    #1;
    check("t6_rst_out_valid", int'(bus.out_valid), 0);
    check_status("t6_rst");
    @(negedge clk); reset = 1'b1;
    ready_mode = 1'b0;
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
